// File: rtl/pulse_train_generator.sv
// Programmable psi pulse generator: period and high time follow a clamped divider.
// The divider is sampled only at period boundaries so psi never glitches mid-period.
module pulse_train_generator #(
  parameter int DIV_W   = 8,
  parameter int MIN_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             psi,
  output logic             period_start,
  output logic             period_done,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(8'h7F);
  localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);

  state_t           r_state;
  logic             r_psi;
  logic             r_start;
  logic             r_done;
  logic             r_busy;
  logic [DIV_W-1:0] r_cur_div;
  logic [DIV_W-1:0] r_count;

  logic [DIV_W-1:0] w_eff;
  logic [DIV_W-1:0] w_h;
  logic [DIV_W-1:0] w_l;

  assign w_eff = (div < MIN_DIV_V) ? MIN_DIV_V : div;
  // Phase lengths come from the latched divider, never the live input.
  assign w_h   = r_cur_div >> 1;
  assign w_l   = r_cur_div - w_h;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_psi     <= 1'b0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_cur_div <= RESET_DIV;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_psi   <= 1'b0;
          r_start <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          if (en) begin
            r_cur_div <= w_eff;
            r_state   <= S_HIGH;
            r_psi     <= 1'b1;
            r_start   <= 1'b1;
            r_busy    <= 1'b1;
            r_count   <= ONE;
          end
        end
        S_HIGH: begin
          r_start <= 1'b0;
          if (r_count == w_h) begin
            r_state <= S_LOW;
            r_psi   <= 1'b0;
            r_count <= ONE;
            r_done  <= (w_l == ONE);
          end else begin
            r_count <= r_count + ONE;
          end
        end
        S_LOW: begin
          if (r_count == w_l) begin
            r_done <= 1'b0;
            if (en) begin
              r_cur_div <= w_eff;
              r_state   <= S_HIGH;
              r_psi     <= 1'b1;
              r_start   <= 1'b1;
              r_count   <= ONE;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_count <= '0;
            end
          end else begin
            r_count <= r_count + ONE;
            r_done  <= ((r_count + ONE) == w_l);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_psi   <= 1'b0;
          r_start <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_count <= '0;
        end
      endcase
    end
  end

  assign psi          = r_psi;
  assign period_start = r_start;
  assign period_done  = r_done;
  assign cur_div      = r_cur_div;
  assign busy         = r_busy;

endmodule
